// File: rtl/axi_to_mem_write_sequencer_if.sv
// Bus bundle for the W-FIFO-to-memory write sequencer: AW request, W FIFO head,
// memory write port and B response, grouped for the sequencer (slave) and its environment (master).
interface axi_to_mem_write_sequencer_if #(
    parameter int unsigned AddrWidth  = 32,
    parameter int unsigned DataWidth  = 64,
    parameter int unsigned IdWidth    = 4,
    parameter int unsigned UserWidth  = 1,
    parameter int unsigned WBeatWidth = DataWidth + DataWidth / 8 + 1 + UserWidth
);
    logic                     aw_valid_i;
    logic                     aw_ready_o;
    logic [AddrWidth-1:0]     aw_addr_i;
    logic [7:0]               aw_len_i;
    logic [2:0]               aw_size_i;
    logic [1:0]               aw_burst_i;
    logic [IdWidth-1:0]       aw_id_i;

    logic [WBeatWidth-1:0]    w_beat_i;
    logic                     w_empty_i;
    logic                     w_pop_o;

    logic                     mem_req_o;
    logic                     mem_gnt_i;
    logic [AddrWidth-1:0]     mem_addr_o;
    logic [DataWidth-1:0]     mem_wdata_o;
    logic [DataWidth/8-1:0]   mem_strb_o;

    logic                     b_valid_o;
    logic                     b_ready_i;
    logic [IdWidth-1:0]       b_id_o;
    logic [1:0]               b_resp_o;

    modport slave (
        input  aw_valid_i, aw_addr_i, aw_len_i, aw_size_i, aw_burst_i, aw_id_i,
        input  w_beat_i, w_empty_i, mem_gnt_i, b_ready_i,
        output aw_ready_o, w_pop_o, mem_req_o, mem_addr_o, mem_wdata_o, mem_strb_o,
        output b_valid_o, b_id_o, b_resp_o
    );

    modport master (
        output aw_valid_i, aw_addr_i, aw_len_i, aw_size_i, aw_burst_i, aw_id_i,
        output w_beat_i, w_empty_i, mem_gnt_i, b_ready_i,
        input  aw_ready_o, w_pop_o, mem_req_o, mem_addr_o, mem_wdata_o, mem_strb_o,
        input  b_valid_o, b_id_o, b_resp_o
    );
endinterface

// File: rtl/axi_to_mem_write_sequencer.sv
// Takes one AW at a time, turns each W FIFO beat into a memory write at the
// computed AXI beat address, and returns a single B response per burst.
module axi_to_mem_write_sequencer #(
    parameter int unsigned AddrWidth  = 32,
    parameter int unsigned DataWidth  = 64,
    parameter int unsigned IdWidth    = 4,
    parameter int unsigned UserWidth  = 1,
    parameter int unsigned WBeatWidth = DataWidth + DataWidth / 8 + 1 + UserWidth
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    axi_to_mem_write_sequencer_if.slave   bus_if
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned LastBit   = UserWidth;
    localparam int unsigned StrbLsb   = UserWidth + 1;
    localparam int unsigned DataLsb   = StrbLsb + StrbWidth;

    localparam logic [2:0] MaxSize = 3'($clog2(StrbWidth));
    localparam logic [AddrWidth-1:0] AddrOne = {{(AddrWidth-1){1'b0}}, 1'b1};

    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstWrap  = 2'b10;
    localparam logic [1:0] BurstRsvd  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        RESP
    } state_e;

    state_e               state_q, state_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [7:0]           len_q, len_d;
    logic [2:0]           size_q, size_d;
    logic [1:0]           burst_q, burst_d;
    logic [IdWidth-1:0]   id_q, id_d;
    logic [7:0]           beat_cnt_q, beat_cnt_d;
    logic                 err_q, err_d;

    logic [DataWidth-1:0] w_data;
    logic [StrbWidth-1:0] w_strb;
    logic                 w_last;
    logic                 unused_w_user;

    logic [AddrWidth-1:0] step_bytes;
    logic [AddrWidth-1:0] wrap_mask;
    logic [AddrWidth-1:0] addr_next;
    logic                 last_beat;
    logic                 beat_fire;

    // Reserved burst type, oversized beats and non-power-of-two WRAP lengths
    // are still executed, but the burst is answered with SLVERR.
    function automatic logic aw_illegal(input logic [1:0] burst,
                                        input logic [2:0] size,
                                        input logic [7:0] len);
        logic bad;
        bad = (burst == BurstRsvd) || (size > MaxSize);
        if (burst == BurstWrap && !(len inside {8'd1, 8'd3, 8'd7, 8'd15})) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

    assign w_data        = bus_if.w_beat_i[DataLsb +: DataWidth];
    assign w_strb        = bus_if.w_beat_i[StrbLsb +: StrbWidth];
    assign w_last        = bus_if.w_beat_i[LastBit];
    assign unused_w_user = ^bus_if.w_beat_i[UserWidth-1:0];

    assign last_beat = (beat_cnt_q == len_q);
    // Grant only qualifies a request already raised from FIFO occupancy, so
    // mem_req_o never depends on mem_gnt_i.
    assign beat_fire = (state_q == BURST) && !bus_if.w_empty_i && bus_if.mem_gnt_i;

    // Next beat address; all arithmetic wraps silently at 2^AddrWidth.
    always_comb begin
        step_bytes = AddrOne << size_q;
        wrap_mask  = ((AddrWidth'(len_q) + AddrOne) << size_q) - AddrOne;
        unique case (burst_q)
            BurstFixed: addr_next = addr_q;
            BurstWrap:  addr_next = (addr_q & ~wrap_mask) | ((addr_q + step_bytes) & wrap_mask);
            default:    addr_next = (addr_q & ~(step_bytes - AddrOne)) + step_bytes;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        size_d     = size_q;
        burst_d    = burst_q;
        id_d       = id_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q;

        bus_if.aw_ready_o  = 1'b0;
        bus_if.w_pop_o     = 1'b0;
        bus_if.mem_req_o   = 1'b0;
        bus_if.mem_addr_o  = '0;
        bus_if.mem_wdata_o = '0;
        bus_if.mem_strb_o  = '0;
        bus_if.b_valid_o   = 1'b0;
        bus_if.b_id_o      = '0;
        bus_if.b_resp_o    = 2'b00;

        unique case (state_q)
            IDLE: begin
                bus_if.aw_ready_o = 1'b1;
                if (bus_if.aw_valid_i) begin
                    addr_d     = bus_if.aw_addr_i;
                    len_d      = bus_if.aw_len_i;
                    size_d     = bus_if.aw_size_i;
                    burst_d    = bus_if.aw_burst_i;
                    id_d       = bus_if.aw_id_i;
                    beat_cnt_d = 8'd0;
                    err_d      = aw_illegal(bus_if.aw_burst_i, bus_if.aw_size_i, bus_if.aw_len_i);
                    state_d    = BURST;
                end
            end

            BURST: begin
                bus_if.mem_req_o   = !bus_if.w_empty_i;
                bus_if.mem_addr_o  = addr_q;
                bus_if.mem_wdata_o = w_data;
                bus_if.mem_strb_o  = w_strb;
                bus_if.w_pop_o     = beat_fire;
                // Beat count follows aw_len only; a misplaced w_last just marks the error.
                if (beat_fire) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    err_d      = err_q | (w_last != last_beat);
                    addr_d     = addr_next;
                    if (last_beat) begin
                        state_d = RESP;
                    end
                end
            end

            RESP: begin
                bus_if.b_valid_o = 1'b1;
                bus_if.b_id_o    = id_q;
                bus_if.b_resp_o  = err_q ? 2'b10 : 2'b00;
                if (bus_if.b_ready_i) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            id_q       <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            size_q     <= size_d;
            burst_q    <= burst_d;
            id_q       <= id_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_axi_to_mem_write_sequencer.sv
// Directed bench for axi_to_mem_write_sequencer: a transaction-level model
// predicts beat addresses, handshakes and responses and is compared every cycle.
module tb_axi_to_mem_write_sequencer;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int IW = 4;
    localparam int UW = 1;
    localparam int SW = DW / 8;
    localparam int BW = DW + SW + 1 + UW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_to_mem_write_sequencer_if #(
        .AddrWidth(AW), .DataWidth(DW), .IdWidth(IW), .UserWidth(UW)
    ) bus ();

    axi_to_mem_write_sequencer #(
        .AddrWidth(AW), .DataWidth(DW), .IdWidth(IW), .UserWidth(UW)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus_if (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // W FIFO model and transaction-level expectation state
    logic [BW-1:0] wq[$];
    logic          pop_seen = 1'b0;

    typedef enum {M_IDLE, M_BURST, M_RESP} mphase_e;
    mphase_e     ph = M_IDLE;
    logic [31:0] m_start;
    int          m_len, m_size, m_idx;
    logic [1:0]  m_burst;
    logic [3:0]  m_id;
    logic        m_err;

    int          aw_taken = 0, b_count = 0, pop_cnt = 0, cyc = 0;
    logic [31:0] got_addr[$];
    int          got_cyc[$];
    logic [1:0]  last_bresp;
    logic [3:0]  last_bid;

    // Address of beat i of a burst, computed directly from the burst geometry.
    function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len,
                                              input int size, input logic [1:0] burst, input int i);
        logic [31:0] stp, wbytes, base;
        stp = 32'd1 << size;
        case (burst)
            2'b00: return start;
            2'b10: begin
                wbytes = 32'(len + 1) << size;
                base   = start & ~(wbytes - 32'd1);
                return base | ((start + 32'(i) * stp) & (wbytes - 32'd1));
            end
            default: return (i == 0) ? start : (start & ~(stp - 32'd1)) + 32'(i) * stp;
        endcase
    endfunction

    function automatic logic [BW-1:0] mk_beat(input logic [63:0] d, input logic [7:0] s, input logic last);
        return {d, s, last, 1'b0};
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            chk("rst_aw_ready", 64'(bus.aw_ready_o), 64'd1);
            chk("rst_mem_req", 64'(bus.mem_req_o), 64'd0);
            chk("rst_b_valid", 64'(bus.b_valid_o), 64'd0);
            chk("rst_w_pop", 64'(bus.w_pop_o), 64'd0);
            ph       = M_IDLE;
            pop_seen = 1'b0;
        end else begin
            chk("aw_ready", 64'(bus.aw_ready_o), 64'(ph == M_IDLE));
            chk("b_valid", 64'(bus.b_valid_o), 64'(ph == M_RESP));
            if (ph == M_BURST) begin
                chk("mem_req", 64'(bus.mem_req_o), 64'(!bus.w_empty_i));
                if (!bus.w_empty_i) begin
                    chk("mem_addr", 64'(bus.mem_addr_o), 64'(beat_addr(m_start, m_len, m_size, m_burst, m_idx)));
                    chk("mem_wdata", bus.mem_wdata_o, bus.w_beat_i[BW-1 -: DW]);
                    chk("mem_strb", 64'(bus.mem_strb_o), 64'(bus.w_beat_i[UW+1 +: SW]));
                    chk("w_pop", 64'(bus.w_pop_o), 64'(bus.mem_gnt_i));
                end else begin
                    chk("w_pop_empty", 64'(bus.w_pop_o), 64'd0);
                end
            end else begin
                chk("mem_req_off", 64'(bus.mem_req_o), 64'd0);
                chk("w_pop_off", 64'(bus.w_pop_o), 64'd0);
            end
            if (ph == M_RESP) begin
                chk("b_id", 64'(bus.b_id_o), 64'(m_id));
                chk("b_resp", 64'(bus.b_resp_o), 64'({m_err, 1'b0}));
            end
            pop_seen = bus.w_pop_o;

            case (ph)
                M_IDLE: if (bus.aw_valid_i) begin
                    m_start = bus.aw_addr_i;
                    m_len   = int'(bus.aw_len_i);
                    m_size  = int'(bus.aw_size_i);
                    m_burst = bus.aw_burst_i;
                    m_id    = bus.aw_id_i;
                    m_idx   = 0;
                    m_err   = (m_burst == 2'b11) || (m_size > 3) ||
                              (m_burst == 2'b10 && !(m_len inside {1, 3, 7, 15}));
                    aw_taken++;
                    ph = M_BURST;
                end
                M_BURST: if (!bus.w_empty_i && bus.mem_gnt_i) begin
                    got_addr.push_back(bus.mem_addr_o);
                    got_cyc.push_back(cyc);
                    pop_cnt++;
                    if (bus.w_beat_i[UW] != (m_idx == m_len)) m_err = 1'b1;
                    if (m_idx == m_len) ph = M_RESP;
                    m_idx++;
                end
                M_RESP: if (bus.b_ready_i) begin
                    last_bresp = bus.b_resp_o;
                    last_bid   = bus.b_id_o;
                    b_count++;
                    ph = M_IDLE;
                end
                default: ph = M_IDLE;
            endcase
        end
    end

    task automatic drive_fifo();
        bus.w_empty_i = (wq.size() == 0);
        bus.w_beat_i  = (wq.size() == 0) ? '0 : wq[0];
    endtask

    task automatic step();
        @(posedge clk);
        if (pop_seen && wq.size() > 0) void'(wq.pop_front());
        #1;
        drive_fifo();
    endtask

    task automatic send_aw(input logic [31:0] addr, input int len, input int size,
                           input logic [1:0] burst, input logic [3:0] id);
        int n0;
        n0             = aw_taken;
        bus.aw_addr_i  = addr;
        bus.aw_len_i   = 8'(len);
        bus.aw_size_i  = 3'(size);
        bus.aw_burst_i = burst;
        bus.aw_id_i    = id;
        bus.aw_valid_i = 1'b1;
        for (int k = 0; k < 20 && aw_taken == n0; k++) step();
        if (aw_taken == n0) chk("aw_timeout", 64'd0, 64'd1);
        bus.aw_valid_i = 1'b0;
    endtask

    task automatic wait_b();
        int n0;
        n0 = b_count;
        for (int k = 0; k < 60 && b_count == n0; k++) step();
        if (b_count == n0) chk("b_timeout", 64'd0, 64'd1);
    endtask

    task automatic clear_log();
        got_addr.delete();
        got_cyc.delete();
        pop_cnt = 0;
    endtask

    task automatic check_addrs(input string tag, input logic [31:0] exp_q[$]);
        chk({tag, "_nbeats"}, 64'(got_addr.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s_addr%0d", tag, i),
                64'((i < got_addr.size()) ? got_addr[i] : 32'hDEAD_BEEF), 64'(exp_q[i]));
    endtask

    initial begin
        logic [31:0] exp_q[$];
        logic        pat[5];

        bus.aw_valid_i = 1'b0;
        bus.aw_addr_i  = '0;
        bus.aw_len_i   = '0;
        bus.aw_size_i  = '0;
        bus.aw_burst_i = '0;
        bus.aw_id_i    = '0;
        bus.mem_gnt_i  = 1'b0;
        bus.b_ready_i  = 1'b1;
        drive_fifo();

        chk("model_wrap_b1", 64'(beat_addr(32'h1018, 3, 3, 2'b10, 1)), 64'h1000);
        chk("model_incr_b2", 64'(beat_addr(32'h1003, 3, 2, 2'b01, 2)), 64'h1008);
        chk("model_fixed_b2", 64'(beat_addr(32'h2004, 2, 2, 2'b00, 2)), 64'h2004);

        step();
        step();
        rst_n = 1'b1;
        step();

        // INCR 4 beats, grant held high
        clear_log();
        for (int i = 0; i < 4; i++) wq.push_back(mk_beat(64'h1100 + 64'(i), 8'hFF, i == 3));
        drive_fifo();
        bus.mem_gnt_i = 1'b1;
        send_aw(32'h1000, 3, 3, 2'b01, 4'h5);
        wait_b();
        exp_q = {32'h1000, 32'h1008, 32'h1010, 32'h1018};
        check_addrs("t1", exp_q);
        chk("t1_back_to_back", 64'((got_cyc.size() == 4) ? got_cyc[3] - got_cyc[0] : -1), 64'd3);
        chk("t1_pops", 64'(pop_cnt), 64'd4);
        chk("t1_resp", 64'(last_bresp), 64'd0);
        chk("t1_id", 64'(last_bid), 64'h5);

        // WRAP 4 beats starting mid-window
        clear_log();
        for (int i = 0; i < 4; i++) wq.push_back(mk_beat(64'h2200 + 64'(i), 8'hFF, i == 3));
        drive_fifo();
        send_aw(32'h1018, 3, 3, 2'b10, 4'h6);
        wait_b();
        exp_q = {32'h1018, 32'h1000, 32'h1008, 32'h1010};
        check_addrs("t2", exp_q);
        chk("t2_resp", 64'(last_bresp), 64'd0);

        // FIXED with toggling grant
        clear_log();
        for (int i = 0; i < 3; i++) wq.push_back(mk_beat(64'h3300 + 64'(i), 8'hF0, i == 2));
        drive_fifo();
        send_aw(32'h2004, 2, 2, 2'b00, 4'h7);
        pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 5; k++) begin
            bus.mem_gnt_i = pat[k];
            #1;
            if (!pat[k]) chk($sformatf("t3_hold_data%0d", k), bus.mem_wdata_o, 64'h3300 + 64'((k + 1) / 2));
            step();
        end
        bus.mem_gnt_i = 1'b1;
        wait_b();
        exp_q = {32'h2004, 32'h2004, 32'h2004};
        check_addrs("t3", exp_q);
        chk("t3_pops", 64'(pop_cnt), 64'd3);
        chk("t3_resp", 64'(last_bresp), 64'd0);

        // INCR len 1 with w_last on the first beat
        clear_log();
        for (int i = 0; i < 2; i++) wq.push_back(mk_beat(64'h4400 + 64'(i), 8'hFF, i == 0));
        drive_fifo();
        send_aw(32'h3000, 1, 3, 2'b01, 4'h2);
        wait_b();
        exp_q = {32'h3000, 32'h3008};
        check_addrs("t4", exp_q);
        chk("t4_pops", 64'(pop_cnt), 64'd2);
        chk("t4_resp", 64'(last_bresp), 64'h2);

        // FIFO runs dry for three cycles mid-burst
        clear_log();
        for (int i = 0; i < 2; i++) wq.push_back(mk_beat(64'h5500 + 64'(i), 8'hFF, 1'b0));
        drive_fifo();
        send_aw(32'h4000, 3, 3, 2'b01, 4'h3);
        step();
        step();
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("t5_gap_req%0d", k), 64'(bus.mem_req_o), 64'd0);
            chk($sformatf("t5_gap_pop%0d", k), 64'(bus.w_pop_o), 64'd0);
            step();
        end
        for (int i = 2; i < 4; i++) wq.push_back(mk_beat(64'h5500 + 64'(i), 8'hFF, i == 3));
        drive_fifo();
        wait_b();
        exp_q = {32'h4000, 32'h4008, 32'h4010, 32'h4018};
        check_addrs("t5", exp_q);
        chk("t5_pops", 64'(pop_cnt), 64'd4);
        chk("t5_resp", 64'(last_bresp), 64'd0);

        // B backpressure for five cycles
        clear_log();
        bus.b_ready_i = 1'b0;
        wq.push_back(mk_beat(64'h6600, 8'hFF, 1'b1));
        drive_fifo();
        send_aw(32'h5000, 0, 3, 2'b01, 4'h9);
        for (int k = 0; k < 20 && !bus.b_valid_o; k++) step();
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("t6_bvalid%0d", k), 64'(bus.b_valid_o), 64'd1);
            chk($sformatf("t6_bid%0d", k), 64'(bus.b_id_o), 64'h9);
            chk($sformatf("t6_awready%0d", k), 64'(bus.aw_ready_o), 64'd0);
            step();
        end
        bus.b_ready_i = 1'b1;
        wait_b();
        chk("t6_resp", 64'(last_bresp), 64'd0);
        chk("t6_id", 64'(last_bid), 64'h9);

        // Asynchronous reset in the middle of a stalled burst
        clear_log();
        for (int i = 0; i < 2; i++) wq.push_back(mk_beat(64'h7700 + 64'(i), 8'hFF, 1'b0));
        drive_fifo();
        bus.mem_gnt_i = 1'b0;
        send_aw(32'h6000, 3, 3, 2'b01, 4'h4);
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_aw_ready", 64'(bus.aw_ready_o), 64'd1);
        chk("t7_mem_req", 64'(bus.mem_req_o), 64'd0);
        chk("t7_b_valid", 64'(bus.b_valid_o), 64'd0);
        wq.delete();
        drive_fifo();
        bus.mem_gnt_i = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("t7_no_resp", 64'(b_count), 64'd6);

        // Reserved burst type: steps as INCR, answered with SLVERR
        clear_log();
        for (int i = 0; i < 2; i++) wq.push_back(mk_beat(64'h8800 + 64'(i), 8'hFF, i == 1));
        drive_fifo();
        send_aw(32'h7004, 1, 3, 2'b11, 4'hA);
        wait_b();
        exp_q = {32'h7004, 32'h7008};
        check_addrs("t8", exp_q);
        chk("t8_resp", 64'(last_bresp), 64'h2);
        chk("t8_id", 64'(last_bid), 64'hA);

        // Beat size wider than the data bus
        clear_log();
        wq.push_back(mk_beat(64'h9900, 8'hFF, 1'b1));
        drive_fifo();
        send_aw(32'h7100, 0, 4, 2'b01, 4'hB);
        wait_b();
        exp_q = {32'h7100};
        check_addrs("t9", exp_q);
        chk("t9_resp", 64'(last_bresp), 64'h2);

        step();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule

// File: doc/axi_to_mem_write_sequencer.md
Name: axi_to_mem_write_sequencer

Overview:
Downstream consumer of the W-channel FIFO in the axi_to_mem path. It accepts one AXI write address (AW) at a time and pops W beats from the FIFO head. For each beat it issues one memory write request with the computed beat address. After the final beat is granted, it returns a B response. It sits between the AW/W buffering stage and the memory request port.

Parameters:
AddrWidth, 32, byte address width of AW and memory port
DataWidth, 64, W data width in bits (power of two, >= 8)
IdWidth, 4, AXI ID width
UserWidth, 1, W user width
WBeatWidth, DataWidth+DataWidth/8+1+UserWidth, packed W beat width. Packing MSB->LSB is {data, strb, last, user}, matching the W FIFO data_o.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
aw_valid_i  in  1  AW request valid
aw_ready_o  out  1  AW accepted
aw_addr_i  in  AddrWidth  start byte address
aw_len_i  in  8  beats minus one
aw_size_i  in  3  log2 bytes per beat
aw_burst_i  in  2  00 FIXED, 01 INCR, 10 WRAP
aw_id_i  in  IdWidth  transaction ID
w_beat_i  in  WBeatWidth  W FIFO head (FIFO data_o)
w_empty_i  in  1  W FIFO empty_o
w_pop_o  out  1  W FIFO pop_i
mem_req_o  out  1  memory write request
mem_gnt_i  in  1  memory grant
mem_addr_o  out  AddrWidth  beat byte address
mem_wdata_o  out  DataWidth  beat data
mem_strb_o  out  DataWidth/8  beat byte strobes
b_valid_o  out  1  write response valid
b_ready_i  in  1  write response accepted
b_id_o  out  IdWidth  response ID
b_resp_o  out  2  00 OKAY, 10 SLVERR

Behaviour:
- FSM states: IDLE, BURST, RESP. Reset: IDLE, beat_cnt=0, err=0, addr/len/size/burst/id regs=0. All outputs 0 in reset, except aw_ready_o=1 (IDLE).
- IDLE:
  - aw_ready_o=1.
  - On aw_valid_i: latch addr/len/size/burst/id, beat_cnt=0, err=0, go to BURST.
  - Set err=1 if aw_burst_i==11 or aw_size_i > log2(DataWidth/8).
  - Set err=1 if burst is WRAP and len is not in {1,3,7,15}.
- BURST:
  - mem_req_o = ~w_empty_i. mem_addr_o = current addr. wdata/strb come from w_beat_i.
  - w_pop_o = mem_req_o & mem_gnt_i. Request and data are held stable while ungranted.
  - No combinational path from mem_gnt_i to mem_req_o.
- On granted beat:
  - beat_cnt++.
  - err |= (w_last != (beat_cnt==len)).
  - Address update:
    - INCR: addr = (addr & ~((1<<size)-1)) + (1<<size). No 4 KiB check.
    - FIXED: addr unchanged.
    - WRAP: W = (len+1)<<size; addr = (addr & ~(W-1)) | ((addr + (1<<size)) & (W-1)).
    - Reserved burst (11): step as INCR.
  - If beat_cnt==len: go to RESP.
- Beat count is governed only by aw_len. w_last mismatch is flagged, never used to shorten or extend the burst.
- RESP:
  - b_valid_o=1, b_id_o=id, b_resp_o = err ? 10 : 00. Held until b_ready_i.
  - On b_ready_i: go to IDLE. The next AW is accepted no earlier than the following cycle, giving 1 idle cycle between bursts.
- Latency: first mem_req_o one cycle after the AW handshake, if the FIFO is non-empty. Back-to-back beats are possible with gnt held high. b_valid_o is asserted the cycle after the last grant.
- Address arithmetic is modulo 2^AddrWidth; wrap-around of the address space is silent.
- Asynchronous reset mid-burst returns to IDLE immediately. No response is issued for the aborted burst.

Test Plan:
- INCR, addr 0x1000, len 3, size 3, DataWidth 64, gnt held 1, 4 beats, last on beat 3 -> mem_addr 0x1000/0x1008/0x1010/0x1018 on consecutive cycles; 4 pops; B resp 00 with matching ID.
- WRAP, addr 0x1018, len 3, size 3 -> addresses 0x1018, 0x1000, 0x1008, 0x1010; B resp 00.
- FIXED, addr 0x2004, len 2, size 2; gnt toggles 1,0,1,0,1 -> addr 0x2004 on every beat; data held during gnt=0; exactly 3 pops.
- INCR, len 1, but w_last set on beat 0 -> 2 beats still issued; B resp 10.
- FIFO empty for 3 cycles mid-burst -> mem_req_o=0 and w_pop_o=0 for those cycles; resumes without lost or duplicated beats.
- b_ready_i low 5 cycles -> b_valid_o and b_id_o stable; aw_ready_o=0 throughout. Reset asserted mid-burst -> aw_ready_o=1, mem_req_o=0, b_valid_o=0.
